// File: rtl/pll_rst_seq.sv
// pll_rst_seq: pulses the PLL reset, qualifies lock, and releases the system reset once lock is stable
module pll_rst_seq #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                  clkin,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  input  logic                  clear_cnt,
  output logic                  pll_reset,
  output logic                  sys_rst_n,
  output logic                  pll_ready,
  output logic [3:0]            retry_cnt,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);
  localparam int RW = $clog2(PLL_RST_CYCLES);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RST_LAST = RW'(PLL_RST_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {PLLRST, WAIT, STABLE, RUN} state_t;
  state_t r_state, w_next;
  logic r_lock_s1, r_lock_s;
  logic [RW-1:0] r_rst_cnt;
  logic [SW-1:0] r_stable_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic r_pll_reset, r_sys_rst_n, r_pll_ready;
  logic [3:0] r_retry;
  logic [LOSS_CNT_W-1:0] r_loss;
  logic w_tmo, w_done, w_retry_inc, w_loss_inc, w_in_qual, w_stay_qual;
  always_comb begin
    w_next      = r_state;
    w_tmo       = (r_tmo_cnt == TMO_LAST);
    w_done      = r_lock_s && (r_stable_cnt == STB_LAST);
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    case (r_state)
      PLLRST: w_next = (r_rst_cnt == RST_LAST) ? WAIT : PLLRST;
      WAIT: begin
        w_next      = w_tmo ? PLLRST : (r_lock_s ? STABLE : WAIT);
        w_retry_inc = w_tmo;
      end
      // completion beats a coincident timeout
      STABLE: begin
        w_next      = w_done ? RUN : (w_tmo ? PLLRST : (r_lock_s ? STABLE : WAIT));
        w_retry_inc = !w_done && w_tmo;
      end
      RUN: begin
        w_next     = r_lock_s ? RUN : WAIT;
        w_loss_inc = !r_lock_s;
      end
      default: w_next = PLLRST;
    endcase
  end
  assign w_in_qual   = (r_state == WAIT) || (r_state == STABLE);
  assign w_stay_qual = w_in_qual && ((w_next == WAIT) || (w_next == STABLE));
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_s1    <= 1'b0;
      r_lock_s     <= 1'b0;
      r_state      <= PLLRST;
      r_rst_cnt    <= '0;
      r_stable_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_pll_reset  <= 1'b1;
      r_sys_rst_n  <= 1'b0;
      r_pll_ready  <= 1'b0;
      r_retry      <= '0;
      r_loss       <= '0;
    end else begin
      r_lock_s1    <= pll_lock;
      r_lock_s     <= r_lock_s1;
      r_state      <= w_next;
      r_rst_cnt    <= (r_state == PLLRST && w_next == PLLRST) ? r_rst_cnt + 1'b1 : '0;
      r_stable_cnt <= (r_state == STABLE && w_next == STABLE) ? r_stable_cnt + 1'b1 : '0;
      r_tmo_cnt    <= w_stay_qual ? r_tmo_cnt + 1'b1 : '0;
      r_pll_reset  <= (w_next == PLLRST);
      r_sys_rst_n  <= (w_next == RUN);
      r_pll_ready  <= (w_next == RUN);
      r_retry      <= clear_cnt ? '0 : ((w_retry_inc && !(&r_retry)) ? r_retry + 1'b1 : r_retry);
      r_loss       <= clear_cnt ? '0 : ((w_loss_inc && !(&r_loss)) ? r_loss + 1'b1 : r_loss);
    end
  end
  assign pll_reset     = r_pll_reset;
  assign sys_rst_n     = r_sys_rst_n;
  assign pll_ready     = r_pll_ready;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_loss;
endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock-high cycles required before release.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 270000 (10 ms at 27 MHz): maximum cycles in WAIT+STABLE before the PLL is re-reset.
REQ-003 SHALL have parameter PLL_RST_CYCLES, default 16: pll_reset pulse width in clkin cycles.
REQ-004 SHALL have parameter LOSS_CNT_W, default 8: width of lock_loss_cnt.
REQ-005 clkin  input  1  27 MHz reference clock, free-running, also feeds the TMDS PLL; sole clock of this block.
REQ-006 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-007 pll_lock  input  1  PLL LOCK, asynchronous to clkin.
REQ-008 clear_cnt  input  1  synchronous clear of retry_cnt and lock_loss_cnt.
REQ-009 pll_reset  output  1  active-high reset to the PLL RESET pin.
REQ-010 sys_rst_n  output  1  active-low reset for the pixel/serializer logic; re-synchronized downstream.
REQ-011 pll_ready  output  1  high while the PLL is locked and qualified.
REQ-012 retry_cnt  output  4  saturating count of timeout-triggered PLL resets.
REQ-013 lock_loss_cnt  output  LOSS_CNT_W  saturating count of lock drops while in RUN.

Function
REQ-014 pll_lock SHALL pass through a 2-flop synchronizer (lock_s); 2-cycle latency; no other logic SHALL sample pll_lock.
REQ-015 FSM states SHALL be PLLRST, WAIT, STABLE, RUN.
REQ-016 PLLRST: rst_cnt counts from 0; at PLL_RST_CYCLES-1 -> WAIT; pll_reset=1 for exactly PLL_RST_CYCLES cycles.
REQ-017 WAIT: lock_s=1 -> STABLE with stable_cnt=0; else remain.
REQ-018 STABLE: stable_cnt increments each lock_s=1 cycle; at LOCK_STABLE_CYCLES-1 -> RUN; lock_s=0 -> WAIT, stable_cnt cleared.
REQ-019 Timeout timer SHALL run across WAIT and STABLE, clear on entry to PLLRST and RUN; at LOCK_TIMEOUT_CYCLES-1 -> PLLRST and retry_cnt+1.
REQ-020 Stable completion and timeout in the same cycle: stable SHALL win (-> RUN, no retry increment).
REQ-021 RUN: lock_s=0 -> WAIT and lock_loss_cnt+1; no direct PLL reset (timeout governs).
REQ-022 Outputs SHALL be registered and decoded from next state, so they change in the same cycle as the state register: pll_reset=(PLLRST), sys_rst_n=(RUN), pll_ready=(RUN).
REQ-023 sys_rst_n SHALL fall in the same cycle RUN is left; no glitches on any output.
REQ-024 retry_cnt SHALL saturate at 15; lock_loss_cnt at 2^LOSS_CNT_W-1; no wrap.
REQ-025 clear_cnt=1 SHALL zero both counters next cycle; clear SHALL win over a simultaneous increment.
REQ-026 Counter widths SHALL be sized with $clog2 of their parameter; parameters SHALL be >=2.

Reset
REQ-027 rst_n=0 SHALL asynchronously force: state=PLLRST, pll_reset=1, sys_rst_n=0, pll_ready=0, all counters and synchronizer flops 0.
REQ-028 After rst_n rises (synchronously used), PLLRST SHALL run its full PLL_RST_CYCLES count.
REQ-029 Reset assertion mid-operation (any state) SHALL take effect immediately without waiting for clkin.

Verification (LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, PLL_RST_CYCLES=4)
REQ-030 Release rst_n, raise pll_lock 10 cycles later, hold -> pll_reset high 4 cycles, sys_rst_n/pll_ready rise 2+8 cycles after lock edge enters WAIT path, retry_cnt=0.
REQ-031 Hold pll_lock=0 -> pll_reset re-pulses 4 cycles every 4+64 cycles; retry_cnt counts 1,2,... saturating at 15.
REQ-032 In RUN drop pll_lock 1 cycle -> sys_rst_n low 2 cycles after drop, lock_loss_cnt=1, re-release 8 qualified cycles after lock_s returns.
REQ-033 In STABLE toggle pll_lock low at count 5 -> stable_cnt restarts, no RUN until 8 consecutive; lock arranged so stable completes on timeout cycle -> RUN, retry_cnt unchanged.
REQ-034 clear_cnt asserted in the same cycle as a lock-loss increment -> lock_loss_cnt=0 next cycle.
REQ-035 Assert rst_n=0 mid-RUN between clkin edges -> sys_rst_n=0, pll_reset=1 immediately; full sequence repeats after release.
